// File: rtl/branch_resolve_unit.sv
// branch_resolve_unit: in-order prediction record FIFO between IF and EX.
// Resolves each record at EX, emits flush/redirect and BTB update pulses.
module branch_resolve_unit #(
   parameter int DEPTH = 4,
   parameter int CNT_W = 16
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push,
   input  logic [31:0]              push_pc,
   input  logic                     push_hit,
   input  logic [31:0]              push_pred_pc,
   input  logic                     ex_valid,
   input  logic [31:0]              ex_pc,
   input  logic                     ex_is_br,
   input  logic                     ex_br_en,
   input  logic [31:0]              ex_target,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     mispredict,
   output logic [31:0]              redirect_pc,
   output logic                     btb_load,
   output logic                     br_en,
   output logic [31:0]              pc_address_ex,
   output logic [31:0]              br_address,
   output logic                     order_err,
   output logic [CNT_W-1:0]         br_count,
   output logic [CNT_W-1:0]         mp_count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   typedef struct packed {
      logic [31:0] pc;
      logic        hit;
      logic [31:0] pred_pc;
   } rec_t;

   rec_t            mem [DEPTH];
   logic [AW-1:0]   wr_ptr;
   logic [AW-1:0]   rd_ptr;
   logic [CW-1:0]   cnt;

   rec_t            head;
   logic            pop;
   logic            push_ok;
   logic            pop_on_empty;
   logic            pc_mismatch;
   logic [31:0]     actual;
   logic [31:0]     predicted;
   logic            miss;

   assign full  = (cnt == CW'(DEPTH));
   assign empty = (cnt == '0);
   assign count = cnt;
   assign head  = mem[rd_ptr];

   // Resolution compare and handshake qualification; a flush cycle
   // treats both push and ex_valid as wrong-path and ignores them.
   always_comb begin
      pop          = ex_valid && !empty && !mispredict;
      push_ok      = push && (!full || pop) && !mispredict;
      pop_on_empty = ex_valid && empty && !mispredict;
      pc_mismatch  = pop && (ex_pc != head.pc);
      actual       = (ex_is_br && ex_br_en) ? ex_target
                                            : ex_pc + 32'd4;
      predicted    = head.hit ? head.pred_pc
                              : head.pc + 32'd4;
      miss         = pop && (actual != predicted);
   end

   // Record storage; contents need no reset since cnt gates every read.
   always_ff @(posedge clk) begin
      if (push_ok) begin
         mem[wr_ptr] <= '{pc: push_pc,
                          hit: push_hit,
                          pred_pc: push_pred_pc};
      end
   end

   // Pointer and occupancy tracking, cleared wholesale on a flush.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
      end else if (mispredict) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + AW'(1);
         if (pop)     rd_ptr <= rd_ptr + AW'(1);
         cnt <= cnt + CW'(push_ok) - CW'(pop);
      end
   end

   // Registered flush/redirect and BTB update pulses; data holds.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mispredict    <= 1'b0;
         redirect_pc   <= '0;
         btb_load      <= 1'b0;
         br_en         <= 1'b0;
         pc_address_ex <= '0;
         br_address    <= '0;
      end else begin
         mispredict <= miss;
         btb_load   <= pop && ex_is_br;
         if (pop) begin
            redirect_pc   <= actual;
            br_en         <= ex_br_en;
            pc_address_ex <= ex_pc;
            br_address    <= ex_target;
         end
      end
   end

   // Sticky ordering error: resolve on empty or PC out of order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         order_err <= 1'b0;
      end else if (pop_on_empty || pc_mismatch) begin
         order_err <= 1'b1;
      end
   end

   // Saturating counters, stepping in the same edge as their pulses.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         br_count <= '0;
         mp_count <= '0;
      end else begin
         if (pop && ex_is_br && (br_count != '1))
            br_count <= br_count + CNT_W'(1);
         if (miss && (mp_count != '1))
            mp_count <= mp_count + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_branch_resolve_unit.sv
// tb_branch_resolve_unit: directed vectors with a pulse scoreboard.
// Stimulus queues expected pulses; a negedge monitor pops and compares.
module tb_branch_resolve_unit;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        push = 1'b0;
   logic [31:0] push_pc = '0;
   logic        push_hit = 1'b0;
   logic [31:0] push_pred_pc = '0;
   logic        ex_valid = 1'b0;
   logic [31:0] ex_pc = '0;
   logic        ex_is_br = 1'b0;
   logic        ex_br_en = 1'b0;
   logic [31:0] ex_target = '0;
   logic        full, empty;
   logic [2:0]  count;
   logic        mispredict, btb_load, br_en, order_err;
   logic [31:0] redirect_pc, pc_address_ex, br_address;
   logic [15:0] br_count, mp_count;

   branch_resolve_unit #(.DEPTH(4), .CNT_W(16)) dut (
      .clk(clk), .rst_n(rst_n),
      .push(push), .push_pc(push_pc),
      .push_hit(push_hit), .push_pred_pc(push_pred_pc),
      .ex_valid(ex_valid), .ex_pc(ex_pc),
      .ex_is_br(ex_is_br), .ex_br_en(ex_br_en),
      .ex_target(ex_target),
      .full(full), .empty(empty), .count(count),
      .mispredict(mispredict), .redirect_pc(redirect_pc),
      .btb_load(btb_load), .br_en(br_en),
      .pc_address_ex(pc_address_ex), .br_address(br_address),
      .order_err(order_err),
      .br_count(br_count), .mp_count(mp_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        mp;
      logic [31:0] redir;
      logic        btb;
      logic        bren;
      logic [31:0] pcx;
      logic [31:0] bra;
   } exp_t;

   exp_t exp_q[$];
   int   n_chk = 0;
   int   n_pass = 0;

   task automatic chk(input string name,
                      input logic [31:0] act,
                      input logic [31:0] req);
      n_chk++;
      if (act === req) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, req);
   endtask

   task automatic expect_pulse(input logic mp, input logic [31:0] redir,
                               input logic btb, input logic bren,
                               input logic [31:0] pcx,
                               input logic [31:0] bra);
      exp_t e;
      e.mp = mp; e.redir = redir; e.btb = btb;
      e.bren = bren; e.pcx = pcx; e.bra = bra;
      exp_q.push_back(e);
   endtask

   // Monitor: any pulse must match the oldest queued expectation.
   always @(negedge clk) begin
      if (rst_n && (mispredict || btb_load)) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_pulse", {30'd0, mispredict, btb_load}, 32'd0);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            chk("mispredict", {31'd0, mispredict}, {31'd0, e.mp});
            chk("btb_load", {31'd0, btb_load}, {31'd0, e.btb});
            if (e.mp) chk("redirect_pc", redirect_pc, e.redir);
            if (e.btb) begin
               chk("br_en", {31'd0, br_en}, {31'd0, e.bren});
               chk("pc_address_ex", pc_address_ex, e.pcx);
               chk("br_address", br_address, e.bra);
            end
         end
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      push = 1'b0; push_pc = '0; push_hit = 1'b0; push_pred_pc = '0;
      ex_valid = 1'b0; ex_pc = '0; ex_is_br = 1'b0;
      ex_br_en = 1'b0; ex_target = '0;
   endtask

   task automatic set_push(input logic [31:0] pc, input logic hit,
                           input logic [31:0] pred);
      push = 1'b1; push_pc = pc; push_hit = hit; push_pred_pc = pred;
   endtask

   task automatic set_ex(input logic [31:0] pc, input logic isbr,
                         input logic ben, input logic [31:0] tgt);
      ex_valid = 1'b1; ex_pc = pc; ex_is_br = isbr;
      ex_br_en = ben; ex_target = tgt;
   endtask

   initial begin
      idle();
      #12;
      chk("rst_empty", {31'd0, empty}, 32'd1);
      chk("rst_count", {29'd0, count}, 32'd0);
      chk("rst_full", {31'd0, full}, 32'd0);
      chk("rst_pulses", {30'd0, mispredict, btb_load}, 32'd0);
      chk("rst_order_err", {31'd0, order_err}, 32'd0);
      rst_n = 1'b1;
      cyc();

      // Correct taken prediction
      set_push(32'h100, 1'b1, 32'h180); cyc(); idle();
      chk("t1_count", {29'd0, count}, 32'd1);
      set_ex(32'h100, 1'b1, 1'b1, 32'h180);
      expect_pulse(1'b0, 32'h0, 1'b1, 1'b1, 32'h100, 32'h180);
      cyc(); idle();
      chk("t1_br_count", {16'd0, br_count}, 32'd1);
      chk("t1_mp_count", {16'd0, mp_count}, 32'd0);
      cyc();

      // Missed taken branch; wrong-path push/ex during flush
      set_push(32'h200, 1'b0, 32'h0); cyc(); idle();
      set_ex(32'h200, 1'b1, 1'b1, 32'h40);
      expect_pulse(1'b1, 32'h40, 1'b1, 1'b1, 32'h200, 32'h40);
      cyc(); idle();
      set_push(32'h999, 1'b0, 32'h0);
      set_ex(32'h999, 1'b0, 1'b0, 32'h0);
      cyc(); idle();
      chk("t2_count", {29'd0, count}, 32'd0);
      chk("t2_empty", {31'd0, empty}, 32'd1);
      chk("t2_mp_count", {16'd0, mp_count}, 32'd1);
      chk("t2_order_err", {31'd0, order_err}, 32'd0);

      // False hit on not-taken branch
      set_push(32'h300, 1'b1, 32'h500); cyc(); idle();
      set_ex(32'h300, 1'b1, 1'b0, 32'h500);
      expect_pulse(1'b1, 32'h304, 1'b1, 1'b0, 32'h300, 32'h500);
      cyc(); idle(); cyc();

      // Stale BTB alias on a non-branch
      set_push(32'h400, 1'b1, 32'h800); cyc(); idle();
      set_ex(32'h400, 1'b0, 1'b0, 32'h0);
      expect_pulse(1'b1, 32'h404, 1'b0, 1'b0, 32'h0, 32'h0);
      cyc(); idle(); cyc();
      chk("t4_br_count", {16'd0, br_count}, 32'd3);
      chk("t4_mp_count", {16'd0, mp_count}, 32'd3);

      // Full, dropped push, push+pop across wrap
      for (int i = 0; i < 4; i++) begin
         set_push(32'h1000 + 32'(4 * i), 1'b0, 32'h0); cyc();
      end
      idle();
      chk("t5_full", {31'd0, full}, 32'd1);
      set_push(32'h2000, 1'b0, 32'h0); cyc(); idle();
      chk("t5_drop_count", {29'd0, count}, 32'd4);
      for (int i = 4; i < 10; i++) begin
         set_push(32'h1000 + 32'(4 * i), 1'b0, 32'h0);
         set_ex(32'h1000 + 32'(4 * (i - 4)), 1'b1, 1'b0, 32'h7000);
         expect_pulse(1'b0, 32'h0, 1'b1, 1'b0,
                      32'h1000 + 32'(4 * (i - 4)), 32'h7000);
         cyc();
         chk("t5_pp_count", {29'd0, count}, 32'd4);
      end
      idle();
      for (int i = 6; i < 10; i++) begin
         set_ex(32'h1000 + 32'(4 * i), 1'b1, 1'b0, 32'h7000);
         expect_pulse(1'b0, 32'h0, 1'b1, 1'b0,
                      32'h1000 + 32'(4 * i), 32'h7000);
         cyc();
      end
      idle(); cyc();
      chk("t5_drain_empty", {31'd0, empty}, 32'd1);
      chk("t5_order_err", {31'd0, order_err}, 32'd0);
      chk("t5_br_count", {16'd0, br_count}, 32'd13);

      // Resolve on empty
      set_ex(32'h50, 1'b1, 1'b1, 32'h60); cyc(); idle();
      chk("t6_order_err", {31'd0, order_err}, 32'd1);
      chk("t6_br_count", {16'd0, br_count}, 32'd13);

      // Async reset mid-cycle with records held
      set_push(32'h600, 1'b0, 32'h0); cyc();
      set_push(32'h604, 1'b0, 32'h0); cyc(); idle();
      chk("t7_pre_count", {29'd0, count}, 32'd2);
      #2 rst_n = 1'b0;
      #1;
      chk("t7_count", {29'd0, count}, 32'd0);
      chk("t7_empty", {31'd0, empty}, 32'd1);
      chk("t7_order_err", {31'd0, order_err}, 32'd0);
      chk("t7_br_count", {16'd0, br_count}, 32'd0);
      chk("t7_mp_count", {16'd0, mp_count}, 32'd0);
      chk("t7_redirect", redirect_pc, 32'd0);
      cyc(); cyc();
      #3 rst_n = 1'b1;
      cyc();

      // Out-of-order resolve still emits
      set_push(32'h10, 1'b0, 32'h0); cyc(); idle();
      set_ex(32'h14, 1'b0, 1'b0, 32'h0);
      expect_pulse(1'b1, 32'h18, 1'b0, 1'b0, 32'h0, 32'h0);
      cyc(); idle(); cyc();
      chk("t8_order_err", {31'd0, order_err}, 32'd1);
      chk("t8_mp_count", {16'd0, mp_count}, 32'd1);
      chk("t8_br_count", {16'd0, br_count}, 32'd0);

      cyc(); cyc();
      chk("sb_drained", exp_q.size(), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/branch_resolve_unit.md
Name: branch_resolve_unit

Overview:
Tracks in-flight fetch-stage predictions in order, and resolves each one when its instruction reaches EX. For each resolution it compares the actual next PC with the predicted next PC. On a mismatch it produces a one-cycle flush/redirect, and it produces the BTB update strobe (btb_load, br_en, pc_address_ex, br_address) that writes the branch target buffer. Sits between IF prediction (BTB hit/predicted_pc) and EX branch resolution.

Parameters:
DEPTH, 4, in-flight prediction records (power of two, >=2)
CNT_W, 16, width of saturating performance counters

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
push  input  1  IF hands a fetched instruction's prediction record to the unit this cycle
push_pc  input  32  PC of fetched instruction
push_hit  input  1  BTB hit for push_pc
push_pred_pc  input  32  BTB predicted target (valid when push_hit)
ex_valid  input  1  instruction in EX resolves this cycle
ex_pc  input  32  PC of resolving instruction
ex_is_br  input  1  resolving instruction is a branch/jump
ex_br_en  input  1  branch taken
ex_target  input  32  computed target
full  output  1  DEPTH records held
empty  output  1  no records held
count  output  $clog2(DEPTH)+1  records held
mispredict  output  1  registered one-cycle flush pulse
redirect_pc  output  32  correct next PC, valid with mispredict
btb_load  output  1  registered one-cycle BTB write strobe
br_en  output  1  taken flag for BTB write
pc_address_ex  output  32  BTB write index/tag PC
br_address  output  32  BTB write target
order_err  output  1  sticky: pop on empty FIFO or ex_pc != head PC
br_count  output  CNT_W  resolved branches, saturating
mp_count  output  CNT_W  mispredicts, saturating

Behaviour:
- Reset (rst_n low, async): FIFO empty, count=0, all outputs 0, counters 0, order_err 0.
- Storage: circular FIFO of {pc, hit, pred_pc}; read/write pointers wrap modulo DEPTH. full = (count==DEPTH); empty = (count==0).
- Push is accepted when push && (!full || pop this cycle). Push while full without a pop is dropped; IF must stall on full.
- Pop occurs when ex_valid && !empty && !mispredict. ex_valid on empty: no pop, order_err set.
- Ordering check: on a pop with ex_pc != head.pc, set order_err (sticky until reset). Resolution still proceeds using head record.
- Resolution (cycle N, combinational compare, results registered at N+1):
  - actual = (ex_is_br && ex_br_en) ? ex_target : ex_pc+4
  - predicted = head.hit ? head.pred_pc : head.pc+4
  - Adds are modulo 2^32.
- Cycle N+1:
  - mispredict=1 iff actual != predicted; redirect_pc=actual.
  - btb_load=1 iff ex_is_br; br_en=ex_br_en; pc_address_ex=ex_pc; br_address=ex_target.
  - All are single-cycle pulses; otherwise 0. Data outputs hold their last value.
- Non-branch with head.hit=1 (stale BTB alias) mispredicts to ex_pc+4; btb_load stays 0.
- Flush: in the cycle mispredict=1, the FIFO is cleared (pointers and count to 0), and push and ex_valid are ignored because both are wrong-path.
- Counters, updated at N+1:
  - br_count increments on btb_load.
  - mp_count increments on mispredict.
  - Both saturate at all-ones.
- Simultaneous push and pop (not flushing): count unchanged. When full, the pop frees the slot the push uses.
- Reset asserted mid-operation: immediate clear; no pulse is emitted after reset deasserts.

Test Plan:
- Reset: hold rst_n=0 asynchronously mid-cycle -> all outputs 0, empty=1, count=0 immediately.
- Correct taken prediction: push pc=0x100 hit=1 pred=0x180; then ex_valid pc=0x100 is_br=1 br_en=1 target=0x180 -> next cycle btb_load=1, br_en=1, pc_address_ex=0x100, br_address=0x180, mispredict=0, br_count=1.
- Missed taken branch: push pc=0x200 hit=0; resolve taken target=0x40 -> mispredict=1, redirect_pc=0x40, FIFO emptied, a push in that cycle is ignored (count=0 after), mp_count=1.
- False hit on not-taken: push pc=0x300 hit=1 pred=0x500; resolve is_br=1 br_en=0 -> mispredict=1, redirect_pc=0x304, btb_load=1, br_en=0.
- Full/wrap: push 4 records (full=1); a fifth push alone is dropped. Push+pop in the same cycle keeps count=4. Repeat for 10 records across pointer wrap; each head pc matches in order, order_err=0.
- Errors: ex_valid on empty -> order_err=1 with no pulse. After reset, push pc=0x10 then resolve ex_pc=0x14 -> order_err=1, resolution still emitted.
